// File: rtl/floating_division.sv
// Sequential IEEE-754 single-precision divider (result = A / B).
// Restoring mantissa division, one quotient bit per clock, start/busy/done
// handshake. Numeric conventions match the combinational FP multiplier:
// hidden-1 mantissas, truncation (no rounding), denormals flushed to zero.
// Only WIDTH = 32 is supported; bit positions below assume single precision.
module floating_division #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state;
    state_t nextState;

    // Operation context captured at accept time.
    logic               signReg;
    logic signed [9:0]  expTmp;
    logic [24:0]        rem;       // partial remainder; always < 2 * divisor
    logic [23:0]        divisor;   // {1, B fraction}
    logic [24:0]        quot;      // quot[24] is the integer bit of the ratio
    logic [4:0]         cnt;

    // Operand decode, valid while the FSM is idle.
    logic [7:0]         expA;
    logic [7:0]         expB;
    logic               opSign;
    logic               isNan;
    logic               isDivZero;
    logic               isZeroA;
    logic               isSpecial;
    logic signed [9:0]  expCalc;

    // One restoring-division step.
    logic [24:0]        remSub;
    logic               remGe;
    logic [24:0]        remNext;

    // Normalisation of the finished quotient.
    logic [22:0]        normMan;
    logic signed [9:0]  normExp;
    logic [31:0]        normResult;

    assign expA      = A[30:23];
    assign expB      = B[30:23];
    assign opSign    = A[31] ^ B[31];
    assign isNan     = (expA == 8'hFF) || (expB == 8'hFF);
    assign isDivZero = (expB == 8'h00);
    assign isZeroA   = (expA == 8'h00);
    assign isSpecial = isNan || isDivZero || isZeroA;
    assign expCalc   = $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'sd127;

    assign remSub  = rem - {1'b0, divisor};
    assign remGe   = (rem >= {1'b0, divisor});
    assign remNext = remGe ? {remSub[23:0], 1'b0} : {rem[23:0], 1'b0};

    // Select mantissa/exponent from the quotient and clamp the exponent range.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        normMan    = quot[22:0];
        normExp    = expTmp - 10'sd1;
        normResult = 32'h0;
        if (quot[24]) begin
            normMan = quot[23:1];
            normExp = expTmp;
        end
        if (normExp >= 10'sd255) begin
            normResult = {signReg, 8'hFF, 23'h0};
        end else if (normExp <= 10'sd0) begin
            normResult = {signReg, 8'h00, 23'h0};
        end else begin
            normResult = {signReg, normExp[7:0], normMan};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= nextState;
        end
    end

    // FSM next-state logic; special cases finish from IDLE without dividing.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start && !isSpecial) nextState = DIVIDE;
            DIVIDE:  if (cnt == 5'd24) nextState = NORM;
            NORM:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signReg     <= 1'b0;
            expTmp      <= '0;
            rem         <= '0;
            divisor     <= '0;
            quot        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (isNan) begin
                            result      <= QNAN;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end else if (isDivZero) begin
                            result      <= {opSign, 8'hFF, 23'h0};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else if (isZeroA) begin
                            result      <= {opSign, 8'h00, 23'h0};
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            signReg <= opSign;
                            expTmp  <= expCalc;
                            rem     <= {1'b0, 1'b1, A[22:0]};
                            divisor <= {1'b1, B[22:0]};
                            quot    <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    quot <= {quot[23:0], remGe};
                    rem  <= remNext;
                    cnt  <= cnt + 5'd1;
                end
                NORM: begin
                    result      <= normResult;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
